joyencoder: RTL
===============

# joyencoder

Serial transmitter for the two-joystick shift-register link. It sits on the joystick-adapter side and replaces a pair of cascaded 74HC165 parallel-in/serial-out registers. It captures 16 active-high switch inputs while the host holds `joy_load_n` low, then presents them one bit per `joy_clk` period on `joy_data`, active-low, in the bit order the host decoder expects. All link inputs are asynchronous to `clk` and are synchronised and edge-detected internally.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser; legal range 2..4.
- `clk` in 1: adapter clock; must run at least `4*(SYNC_STAGES+2)` times faster than `joy_clk`.
- `reset` in 1: synchronous, active-high.
- `joy_clk` in 1: link shift clock from the host; asynchronous.
- `joy_load_n` in 1: link parallel-load strobe from the host, active-low; asynchronous.
- `sw` in 16: switch states, 1 = pressed; asynchronous.
  - `[15:8]` = joy2 {up, down, left, right, fire1, fire2, fire3, start}.
  - `[7:0]` = joy1 in the same order.
- `joy_data` out 1: serial data to the host, 0 = pressed.
- `frame_strobe` out 1: one-cycle pulse on the `clk` cycle in which synchronised `joy_load_n` falls.
- `overrun` out 1: sticky flag; set when a 17th shift occurs without an intervening load, cleared by the next load.

## Operation
- **Synchronisers.** `joy_clk`, `joy_load_n` and each `sw` bit pass through `SYNC_STAGES` flops, plus one extra history flop on `joy_clk` and `joy_load_n` for edge detection.
  - Reset values: `joy_clk` chain 0, `joy_load_n` chain 1, `sw` chain 0.
- **Shift register `sr[15:0]`.** `joy_data = sr[0]`, so bit 0 is transmitted first and bit 15 last.
- **Load.** While synchronised `joy_load_n` = 0, every cycle: `sr <= ~sw_sync`, `cnt <= 0`, `overrun <= 0`. Loading is transparent, like the '165 parallel load.
- **Shift.** On a synchronised `joy_clk` rising edge while synchronised `joy_load_n` = 1:
  - `sr <= {1'b1, sr[15:1]}`; the serial input is tied to released (1).
  - `cnt` is 5 bits and saturates at 16.
  - If `cnt` is already 16, set `overrun`.
- **Priority.** Load beats shift in the same cycle. `joy_clk` edges seen while loading are ignored.
- **Falling edges.** Falling edges of `joy_clk` have no effect; the host samples on them.
- **Frame strobe.** `frame_strobe` pulses exactly once per high-to-low transition of synchronised `joy_load_n`. It does not re-fire while `joy_load_n` stays low.
- **Reset.** Reset mid-frame aborts the frame immediately:
  - `sr` = 16'hFFFF, so `joy_data` = 1.
  - `cnt` = 0, `overrun` = 0, `frame_strobe` = 0.
  - Synchroniser flops return to their reset values.
- **Reset values of outputs:** `joy_data` = 1, `frame_strobe` = 0, `overrun` = 0.

## Timing
- **Load latency.** From a `joy_load_n` pin fall to `sr` loaded is `SYNC_STAGES` + 1 `clk` edges. `frame_strobe` is asserted in the same cycle `sr` is first loaded.
- **Shift latency.** From a `joy_clk` pin rise to the updated `joy_data` is `SYNC_STAGES` + 2 `clk` edges. This is far less than the half-period before the host's sampling (falling) edge.
- **Hold.** `joy_data` is stable from the shift update until the next synchronised rising edge. The host's falling-edge sample therefore sees a bit held for about half a `joy_clk` period on each side.
- **Host frame.** One host frame is 16 `joy_clk` periods:
  - Period 0: `joy_load_n` low; the host samples bit 0 at its end.
  - Periods 1..15: each rising edge shifts; the host samples bit k at the falling edge ending period k.
- **Minimum pulse widths.** `joy_clk` high and low widths, and the `joy_load_n` low width, must each be at least `SYNC_STAGES` + 2 `clk` cycles. Narrower pulses may be lost; that is not an error condition.
- **Switch changes.** A `sw` change during the load window is reflected within `SYNC_STAGES` + 1 cycles. A change outside the load window is not reflected until the next load.

## Test plan
- **Reset.** Hold `reset` 3 cycles with `joy_load_n` = 0 and `sw` = 16'hFFFF -> during reset `joy_data` = 1, `overrun` = 0, `frame_strobe` = 0. `frame_strobe` pulses once after release.
- **Full frame.** `sw` = 16'h8001, host model with a 256-`clk` `joy_clk` period, 16-period frame -> host reconstructs ~`joy_data` = 16'h8001. `frame_strobe` pulses once per frame, `overrun` = 0.
- **Walking ones.** For each k = 0..15, `sw` = 1<<k -> only sampled bit k is 0 on `joy_data`; repeat for 3 frames each.
- **Overrun.** After a load with `sw` = 16'h0000, issue 20 rising edges without a load -> `joy_data` = 1 on shifts 16..20. `overrun` sets on the 17th edge and clears on the next `joy_load_n` low.
- **Simultaneous events.**
  - Rising `joy_clk` in the same synchronised cycle as `joy_load_n` falling -> load wins, `joy_data` = ~`sw[0]`, `cnt` = 0.
  - `sw` changes mid-frame -> the current frame is unaffected.
- **Reset mid-frame.** Assert `reset` after 7 shifts -> `joy_data` = 1 immediately after the reset edge. The next load/frame transmits the current `sw` correctly.

Source files
------------

// File: rtl/joyencoder.sv
// joyencoder: '165-style serial transmitter for the two-joystick link.
// Link pins are synchronised to clk; parallel load beats shift.
module joyencoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_clk,
  input  logic        joy_load_n,
  input  logic [15:0] sw,
  output logic        joy_data,
  output logic        frame_strobe,
  output logic        overrun
);

  localparam int         S       = SYNC_STAGES;
  localparam logic [4:0] CNT_MAX = 5'd16;

  logic [S-1:0] jclk_q;
  logic [S-1:0] jld_q;
  logic         jclk_hist_q;
  logic         jld_hist_q;
  logic [15:0]  sw_q [S];

  logic         rise_q;
  logic         rise_d;
  logic [15:0]  sr_q;
  logic [15:0]  sr_d;
  logic [4:0]   cnt_q;
  logic [4:0]   cnt_d;
  logic         ovr_q;
  logic         ovr_d;
  logic         strobe_q;
  logic         strobe_d;

  logic         jclk_s;
  logic         jld_s;
  logic [15:0]  sw_s;

  assign jclk_s = jclk_q[S-1];
  assign jld_s  = jld_q[S-1];
  assign sw_s   = sw_q[S-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      jclk_q      <= '0;
      jld_q       <= '1;
      jclk_hist_q <= 1'b0;
      jld_hist_q  <= 1'b1;
      for (int i = 0; i < S; i++) begin
        sw_q[i] <= '0;
      end
    end else begin
      jclk_q      <= {jclk_q[S-2:0], joy_clk};
      jld_q       <= {jld_q[S-2:0], joy_load_n};
      jclk_hist_q <= jclk_s;
      jld_hist_q  <= jld_s;
      sw_q[0]     <= sw;
      for (int i = 1; i < S; i++) begin
        sw_q[i] <= sw_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q   <= 1'b0;
      sr_q     <= 16'hFFFF;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      strobe_q <= strobe_d;
    end
  end

  // Rising edges seen during a load are dropped before they reach the shifter.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    strobe_d = ~jld_s & jld_hist_q;
    rise_d   = jclk_s & ~jclk_hist_q & jld_s;
    priority case (1'b1)
      ~jld_s: begin
        sr_d  = ~sw_s;
        cnt_d = '0;
        ovr_d = 1'b0;
      end
      rise_q: begin
        sr_d = {1'b1, sr_q[15:1]};
        if (cnt_q == CNT_MAX) begin
          ovr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign joy_data     = sr_q[0];
  assign frame_strobe = strobe_q;
  assign overrun      = ovr_q;

endmodule
